// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter stage.
package pc_pkg;

    // Control state of the PC stage.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } pc_state_e;

    // Source selected for the next PC value.
    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } pc_sel_e;

    // Byte distance between consecutive instructions.
    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates: sequential, branch, jump, and the
// word-alignment check on the register-sourced target.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc_i,
    input  logic [15:0]      branch_off_i,
    input  logic [25:0]      jump_idx_i,
    input  logic [1:0]       jr_low_i,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic [WIDTH-1:0] branch_target_o,
    output logic [WIDTH-1:0] jump_target_o,
    output logic             misaligned_o
);

    logic [WIDTH-1:0] branch_disp;

    // Sequential PC and the sign-extended, word-scaled branch displacement;
    // both sums wrap modulo 2^WIDTH.
    always_comb begin
        pc_plus4_o      = pc_i + WIDTH'(PC_INC);
        branch_disp     = {{(WIDTH-18){branch_off_i[15]}}, branch_off_i, 2'b00};
        branch_target_o = pc_plus4_o + branch_disp;
        misaligned_o    = |jr_low_i;
    end

    // Jump keeps the region bits above bit 27 from pc+4; a 28-bit PC has none.
    generate
        if (WIDTH > 28) begin : g_region
            assign jump_target_o = {pc_plus4_o[WIDTH-1:28], jump_idx_i, 2'b00};
        end else begin : g_noregion
            assign jump_target_o = {jump_idx_i, 2'b00};
        end
    endgenerate

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage: PC register, next-PC selection, RUN/STALL/HALT
// control, registered redirect pulse and saturating taken counter.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_src,
    input  logic [15:0]      branch_off,
    input  logic             jump,
    input  logic [25:0]      jump_idx,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             stall,
    input  logic             halt_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             redirect,
    output logic [CNT_W-1:0] taken_count,
    output logic             misalign_err,
    output logic             halted
);

    pc_state_e        state_q, state_d;
    pc_sel_e          sel;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             redirect_q, redirect_d;
    logic             misalign_q, misalign_d;
    logic             load;
    logic [WIDTH-1:0] branch_target, jump_target;
    logic             misaligned;

    pc_target_calc #(.WIDTH(WIDTH)) u_calc (
        .pc_i            (pc_q),
        .branch_off_i    (branch_off),
        .jump_idx_i      (jump_idx),
        .jr_low_i        (jr_target[1:0]),
        .pc_plus4_o      (pc_plus4),
        .branch_target_o (branch_target),
        .jump_target_o   (jump_target),
        .misaligned_o    (misaligned)
    );

    // State transitions and next-PC source; halt beats stall beats requests.
    always_comb begin
        state_d    = state_q;
        sel        = SEL_SEQ;
        load       = 1'b0;
        redirect_d = 1'b0;
        misalign_d = misalign_q;
        if (state_q != HALT) begin
            if (halt_req) begin
                state_d = HALT;
            end else if (stall) begin
                state_d = STALL;
            end else begin
                state_d = RUN;
                load    = 1'b1;
                if (jr) begin
                    if (misaligned) begin
                        state_d    = HALT;
                        load       = 1'b0;
                        misalign_d = 1'b1;
                    end else begin
                        sel        = SEL_JR;
                        redirect_d = 1'b1;
                    end
                end else if (jump) begin
                    sel        = SEL_J;
                    redirect_d = 1'b1;
                end else if (pc_src) begin
                    sel        = SEL_BR;
                    redirect_d = 1'b1;
                end
            end
        end
    end

    // Next PC value and saturating count of accepted redirects.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            case (sel)
                SEL_JR:  pc_d = jr_target;
                SEL_J:   pc_d = jump_target;
                SEL_BR:  pc_d = branch_target;
                default: pc_d = pc_plus4;
            endcase
        end
        count_d = count_q;
        if (redirect_d && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // All architectural state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            count_q    <= '0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc           = pc_q;
    assign taken_count  = count_q;
    assign redirect     = redirect_q;
    assign misalign_err = misalign_q;
    assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: a vector table for the main
// sequence, plus hand-written misalign, wrap and saturation sequences.
module tb_pc_next_unit;

   // One applied cycle: inputs held across a clock edge, then the outputs
   // expected once that edge has passed.
   typedef struct {
      logic        pcSrc;
      logic [15:0] branchOff;
      logic        jumpReq;
      logic [25:0] jumpIdx;
      logic        jrReq;
      logic [31:0] jrTarget;
      logic        stallReq;
      logic        haltReq;
      logic [31:0] expPc;
      logic        expRedirect;
      logic [15:0] expCount;
      logic        expHalted;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        pcSrc;
   logic [15:0] branchOff;
   logic        jumpReq;
   logic [25:0] jumpIdx;
   logic        jrReq;
   logic [31:0] jrTarget;
   logic        stallReq;
   logic        haltReq;

   logic [31:0] pc, pcPlus4;
   logic        redirect, misalignErr, halted;
   logic [15:0] takenCount;

   logic [31:0] satPc, satPcPlus4;
   logic        satRedirect, satMisalign, satHalted;
   logic [1:0]  satCount;

   int errors = 0;
   int checks = 0;

   vec_t vecs[16];

   // Default-width instance used for most checks.
   pc_next_unit #(.WIDTH(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .pc_src(pcSrc), .branch_off(branchOff),
      .jump(jumpReq), .jump_idx(jumpIdx), .jr(jrReq), .jr_target(jrTarget),
      .stall(stallReq), .halt_req(haltReq), .pc(pc), .pc_plus4(pcPlus4),
      .redirect(redirect), .taken_count(takenCount),
      .misalign_err(misalignErr), .halted(halted)
   );

   // Narrow-counter instance sharing the same stimulus, used for saturation.
   pc_next_unit #(.WIDTH(32), .RESET_PC(32'h0), .CNT_W(2)) dutSat (
      .clk(clk), .rst(rst), .pc_src(pcSrc), .branch_off(branchOff),
      .jump(jumpReq), .jump_idx(jumpIdx), .jr(jrReq), .jr_target(jrTarget),
      .stall(stallReq), .halt_req(haltReq), .pc(satPc), .pc_plus4(satPcPlus4),
      .redirect(satRedirect), .taken_count(satCount),
      .misalign_err(satMisalign), .halted(satHalted)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkVec(logic ps, logic [15:0] off, logic j, logic [25:0] idx,
                                  logic r, logic [31:0] rt, logic st, logic h,
                                  logic [31:0] ePc, logic eRd, logic [15:0] eCnt, logic eH);
      vec_t v;
      v.pcSrc = ps; v.branchOff = off; v.jumpReq = j; v.jumpIdx = idx;
      v.jrReq = r; v.jrTarget = rt; v.stallReq = st; v.haltReq = h;
      v.expPc = ePc; v.expRedirect = eRd; v.expCount = eCnt; v.expHalted = eH;
      return v;
   endfunction

   // Drive one cycle of inputs, then wait past the edge to sample.
   task automatic applyStimulus(input vec_t v);
      pcSrc = v.pcSrc; branchOff = v.branchOff; jumpReq = v.jumpReq;
      jumpIdx = v.jumpIdx; jrReq = v.jrReq; jrTarget = v.jrTarget;
      stallReq = v.stallReq; haltReq = v.haltReq;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic idleCycle();
      applyStimulus(mkVec(0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic doReset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) idleCycle();
      rst = 1'b0;
   endtask

   // Main sequence: reset, table-driven vectors, then corner sequences.
   initial begin
      rst = 1'b1;
      pcSrc = 0; branchOff = '0; jumpReq = 0; jumpIdx = '0;
      jrReq = 0; jrTarget = '0; stallReq = 0; haltReq = 0;

      //               ps off      j  idx      jr rt            st h   pc            rd cnt hlt
      vecs[0]  = mkVec(0, 16'h0000, 0, 26'h0,  0, 32'h0,        0, 0, 32'h0000_0004, 0, 0, 0);
      vecs[1]  = mkVec(0, 16'h0000, 0, 26'h0,  0, 32'h0,        0, 0, 32'h0000_0008, 0, 0, 0);
      vecs[2]  = mkVec(0, 16'h0000, 0, 26'h0,  0, 32'h0,        0, 0, 32'h0000_000C, 0, 0, 0);
      vecs[3]  = mkVec(0, 16'h0000, 0, 26'h0,  0, 32'h0,        0, 0, 32'h0000_0010, 0, 0, 0);
      vecs[4]  = mkVec(1, 16'hFFFE, 0, 26'h0,  0, 32'h0,        0, 0, 32'h0000_000C, 1, 1, 0);
      vecs[5]  = mkVec(0, 16'h0000, 0, 26'h0,  0, 32'h0,        0, 0, 32'h0000_0010, 0, 1, 0);
      vecs[6]  = mkVec(1, 16'hFFFE, 1, 26'h40, 0, 32'h0,        0, 0, 32'h0000_0100, 1, 2, 0);
      vecs[7]  = mkVec(0, 16'h0000, 0, 26'h0,  0, 32'h0,        0, 0, 32'h0000_0104, 0, 2, 0);
      vecs[8]  = mkVec(1, 16'h0004, 0, 26'h0,  0, 32'h0,        1, 0, 32'h0000_0104, 0, 2, 0);
      vecs[9]  = mkVec(1, 16'h0004, 0, 26'h0,  0, 32'h0,        1, 0, 32'h0000_0104, 0, 2, 0);
      vecs[10] = mkVec(1, 16'h0004, 0, 26'h0,  0, 32'h0,        1, 0, 32'h0000_0104, 0, 2, 0);
      vecs[11] = mkVec(0, 16'h0000, 0, 26'h0,  0, 32'h0,        0, 0, 32'h0000_0108, 0, 2, 0);
      vecs[12] = mkVec(1, 16'h0000, 1, 26'h7,  1, 32'h0000_0200, 0, 0, 32'h0000_0200, 1, 3, 0);
      vecs[13] = mkVec(1, 16'h0003, 0, 26'h0,  0, 32'h0,        0, 0, 32'h0000_0210, 1, 4, 0);
      vecs[14] = mkVec(1, 16'h0003, 1, 26'h5,  0, 32'h0,        0, 1, 32'h0000_0210, 0, 4, 1);
      vecs[15] = mkVec(0, 16'h0000, 1, 26'h5,  0, 32'h0,        0, 0, 32'h0000_0210, 0, 4, 1);

      doReset(2);
      checkOutput("reset pc", pc, 32'h0);
      checkOutput("reset pc_plus4", pcPlus4, 32'h4);
      checkOutput("reset redirect", {31'b0, redirect}, 32'h0);
      checkOutput("reset count", {16'b0, takenCount}, 32'h0);
      checkOutput("reset misalign", {31'b0, misalignErr}, 32'h0);
      checkOutput("reset halted", {31'b0, halted}, 32'h0);

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d pc", i), pc, vecs[i].expPc);
         checkOutput($sformatf("vec%0d redirect", i), {31'b0, redirect}, {31'b0, vecs[i].expRedirect});
         checkOutput($sformatf("vec%0d count", i), {16'b0, takenCount}, {16'b0, vecs[i].expCount});
         checkOutput($sformatf("vec%0d halted", i), {31'b0, halted}, {31'b0, vecs[i].expHalted});
      end

      // Misaligned register jump: PC holds, error is sticky, HALT ignores jumps.
      doReset(1);
      idleCycle();
      checkOutput("mis pre pc", pc, 32'h4);
      applyStimulus(mkVec(0, 16'h0, 0, 26'h0, 1, 32'h0000_0202, 0, 0, 0, 0, 0, 0));
      checkOutput("mis pc held", pc, 32'h4);
      checkOutput("mis err", {31'b0, misalignErr}, 32'h1);
      checkOutput("mis halted", {31'b0, halted}, 32'h1);
      checkOutput("mis redirect", {31'b0, redirect}, 32'h0);
      checkOutput("mis count", {16'b0, takenCount}, 32'h0);
      applyStimulus(mkVec(1, 16'h8, 1, 26'h40, 0, 32'h0, 0, 0, 0, 0, 0, 0));
      checkOutput("halt jump ignored", pc, 32'h4);
      checkOutput("halt err sticky", {31'b0, misalignErr}, 32'h1);
      doReset(1);
      checkOutput("rst clears pc", pc, 32'h0);
      checkOutput("rst clears err", {31'b0, misalignErr}, 32'h0);
      checkOutput("rst clears halt", {31'b0, halted}, 32'h0);

      // Jump keeps the upper region bits of pc+4.
      applyStimulus(mkVec(0, 16'h0, 0, 26'h0, 1, 32'h3000_0010, 0, 0, 0, 0, 0, 0));
      checkOutput("jr hi pc", pc, 32'h3000_0010);
      applyStimulus(mkVec(0, 16'h0, 1, 26'h1, 0, 32'h0, 0, 0, 0, 0, 0, 0));
      checkOutput("jump region pc", pc, 32'h3000_0004);

      // Sequential wrap at the top of the address space.
      applyStimulus(mkVec(0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0));
      checkOutput("wrap pre pc", pc, 32'hFFFF_FFFC);
      checkOutput("wrap pc_plus4", pcPlus4, 32'h0);
      idleCycle();
      checkOutput("wrap pc", pc, 32'h0);
      checkOutput("wrap redirect", {31'b0, redirect}, 32'h0);

      // Narrow counter saturates at 3 after five taken branches.
      doReset(1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(mkVec(1, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
         checkOutput($sformatf("sat count %0d", i), {30'b0, satCount},
                     (i < 3) ? 32'(i + 1) : 32'h3);
      end
      checkOutput("sat pc", satPc, 32'h14);

      // Reset asserted during a stall restores reset values.
      applyStimulus(mkVec(0, 16'h0, 0, 26'h0, 0, 32'h0, 1, 0, 0, 0, 0, 0));
      rst = 1'b1;
      applyStimulus(mkVec(0, 16'h0, 0, 26'h0, 0, 32'h0, 1, 0, 0, 0, 0, 0));
      rst = 1'b0;
      checkOutput("stall rst pc", pc, 32'h0);
      checkOutput("stall rst count", {16'b0, takenCount}, 32'h0);
      idleCycle();
      checkOutput("post rst run pc", pc, 32'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
